wave_cmd_parser: RTL and testbench
==================================

WAVE_CMD_PARSER -- requirements
Module: wave_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000, meaning the inter-byte timeout in clk cycles (10 ms at 50 MHz).
REQ-002 SHALL have parameter STEP_RESET, default 16'd1, meaning the reset value of step.
REQ-003 SHALL have parameter AMP_RESET, default 8'd255, meaning the reset value of amplitude.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rx_data, input, 8 bits: received UART byte from the AVR interface.
REQ-007 SHALL have port new_rx_data, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port tx_data, output, 8 bits: reply byte to the AVR interface.
REQ-009 SHALL have port new_tx_data, output, 1 bit: one-cycle strobe qualifying tx_data.
REQ-010 SHALL have port tx_busy, input, 1 bit: high while the transmitter cannot accept a byte.
REQ-011 SHALL have port step, output, 16 bits: phase increment to the signal generator.
REQ-012 SHALL have port wave_sel, output, 2 bits: waveform select (0 ramp, 1 triangle, 2 square, 3 sine).
REQ-013 SHALL have port amplitude, output, 8 bits: output scale for the DAC stage.
REQ-014 SHALL have port cfg_update, output, 1 bit: one-cycle pulse when any of step, wave_sel or amplitude changes.

Function
REQ-015 SHALL parse 5-byte frames: 0xA5 sync, CMD, D_HI, D_LO, CHK, where CHK = CMD xor D_HI xor D_LO.
REQ-016 SHALL implement states IDLE, CMD, DHI, DLO, CHK, EXEC, REPLY.
REQ-017 In IDLE, SHALL discard every byte except 0xA5, which moves the state to CMD.
REQ-018 In CMD, DHI, DLO and CHK, SHALL capture each strobed byte and advance one state; 0xA5 is treated as data, with no resynchronisation.
REQ-019 SHALL set a byte to EXEC at cycle N+1 when its CHK strobe arrives at cycle N; at cycle N+2, updated outputs SHALL be visible with cfg_update high for exactly that one cycle.
REQ-020 Command 0x01 SHALL set step = {D_HI,D_LO}; a value of 0 SHALL be rejected.
REQ-021 Command 0x02 SHALL set wave_sel = D_LO[1:0]; D_LO > 3 SHALL be rejected.
REQ-022 Command 0x03 SHALL set amplitude = D_LO.
REQ-023 A checksum mismatch, an unknown CMD or a rejected value SHALL leave all outputs unchanged, keep cfg_update low, and queue reply 0x15 (NAK); an accepted command SHALL queue 0x06 (ACK).
REQ-024 In REPLY, SHALL pulse new_tx_data for one cycle with tx_data valid, only in a cycle where tx_busy is low; at least one idle cycle SHALL follow each pulse before the next pulse; the first pulse occurs no earlier than cycle N+2.
REQ-025 SHALL drop bytes strobed while in EXEC or REPLY, and return to IDLE after the last reply byte.
REQ-026 SHALL reload a timeout counter on every strobed byte in states CMD..CHK; on reaching TIMEOUT_CYCLES, SHALL return to IDLE with no reply and no output change.
REQ-027 When a byte strobe and a timeout expiry occur in the same cycle, the byte SHALL win.
REQ-028 tx_data SHALL hold its last value between pulses.

Reset
REQ-029 While rst is high at a clk edge, SHALL set state IDLE, step = STEP_RESET, wave_sel = 0, amplitude = AMP_RESET, cfg_update = 0, new_tx_data = 0, tx_data = 0, and timeout counter = 0.
REQ-030 Reset mid-frame or mid-reply SHALL abandon the frame or reply, with no partial byte sent afterwards.

Configuration
REQ-031 With WAVE_CMD_READBACK_EN defined, command 0x04 SHALL be accepted with any data, reply three bytes 0x06, step[15:8], step[7:0], and leave outputs unchanged with cfg_update low.
REQ-032 Without WAVE_CMD_READBACK_EN, command 0x04 SHALL be treated as unknown and replied with NAK.

Verification
REQ-033 Send A5 01 00 10 11 -> step = 0x0010 at the CHK strobe cycle + 2, one cfg_update pulse, and tx_data 0x06 sent once.
REQ-034 Send A5 03 00 80 83, then A5 02 00 05 07 -> amplitude = 0x80 with ACK, then wave_sel unchanged with NAK 0x15.
REQ-035 Send A5 01 00 10 12 (bad CHK) -> step unchanged, cfg_update never high, NAK sent.
REQ-036 Send A5 01, then idle for TIMEOUT_CYCLES, then 00 10 11 -> no reply, step unchanged, state IDLE; then a full valid frame is ACKed.
REQ-037 Hold tx_busy high for 100 cycles during REPLY -> no new_tx_data until tx_busy is low; then exactly one pulse; with the macro defined, A5 04 00 00 04 after REQ-033 -> 06 00 10 with a gap cycle between pulses.
REQ-038 Assert rst for one cycle mid-frame after A5 01 00 -> all outputs at their reset values, no reply, and the next valid frame is accepted.

Source files
------------

// File: rtl/wave_cmd_parser.sv
// Purpose : UART command-frame parser (A5 CMD D_HI D_LO CHK) driving waveform generator settings, with ACK/NAK reply.
// Latency : outputs and cfg_update change two cycles after the CHK byte strobe; first reply pulse possible that same cycle.
// Backpres: reply bytes wait while tx_busy is high; bytes arriving during execute/reply are dropped (no rx backpressure).
//
// Ports   : clk, rst (sync, active-high)
//           rx_data/new_rx_data   - received byte + one-cycle strobe
//           tx_data/new_tx_data   - reply byte + one-cycle strobe, gated by tx_busy
//           step, wave_sel, amplitude, cfg_update - generator settings and change pulse
// Options : WAVE_CMD_READBACK_EN enables command 0x04 (reply 06, step[15:8], step[7:0]).
module wave_cmd_parser #(
    parameter int          TIMEOUT_CYCLES = 500000,
    parameter logic [15:0] STEP_RESET     = 16'd1,
    parameter logic [7:0]  AMP_RESET      = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic [15:0] step,
    output logic [1:0]  wave_sel,
    output logic [7:0]  amplitude,
    output logic        cfg_update
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_DHI   = 3'd2;
    localparam logic [2:0] S_DLO   = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_EXEC  = 3'd5;
    localparam logic [2:0] S_REPLY = 3'd6;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    state;
    logic [7:0]    cmd_q, dhi_q, dlo_q, chk_q;
    logic [TW-1:0] to_cnt;
    logic [7:0]    reply_b0, reply_b1, reply_b2;
    logic [1:0]    reply_idx, reply_last;
    logic [7:0]    reply_byte;
    logic [7:0]    tx_hold;
    logic          gap_q;

    // Frame decode, only meaningful in S_EXEC.
    logic chk_ok, accept, wr_step, wr_wave, wr_amp, readback, changed;

    always_comb begin
        chk_ok   = ((cmd_q ^ dhi_q ^ dlo_q) == chk_q);
        accept   = 1'b0;
        wr_step  = 1'b0;
        wr_wave  = 1'b0;
        wr_amp   = 1'b0;
        readback = 1'b0;
        if (chk_ok) begin
            case (cmd_q)
                8'h01: if ({dhi_q, dlo_q} != 16'd0) begin accept = 1'b1; wr_step = 1'b1; end
                8'h02: if (dlo_q <= 8'd3) begin accept = 1'b1; wr_wave = 1'b1; end
                8'h03: begin accept = 1'b1; wr_amp = 1'b1; end
`ifdef WAVE_CMD_READBACK_EN
                8'h04: begin accept = 1'b1; readback = 1'b1; end
`endif
                default: ;
            endcase
        end
        // cfg_update only fires when a value actually moves.
        changed = (wr_step && ({dhi_q, dlo_q} != step))
               || (wr_wave && (dlo_q[1:0] != wave_sel))
               || (wr_amp  && (dlo_q != amplitude));
    end

    always_comb begin
        reply_byte = reply_b0;
        case (reply_idx)
            2'd1:    reply_byte = reply_b1;
            2'd2:    reply_byte = reply_b2;
            default: ;
        endcase
    end

    // Strobe is combinational on tx_busy so a pulse can only land in a
    // cycle where the transmitter is free; gap_q forces one idle cycle.
    assign new_tx_data = !rst && (state == S_REPLY) && !tx_busy && !gap_q;
    assign tx_data     = new_tx_data ? reply_byte : tx_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            step       <= STEP_RESET;
            wave_sel   <= 2'd0;
            amplitude  <= AMP_RESET;
            cfg_update <= 1'b0;
            to_cnt     <= '0;
            tx_hold    <= 8'd0;
            gap_q      <= 1'b0;
            cmd_q      <= 8'd0;
            dhi_q      <= 8'd0;
            dlo_q      <= 8'd0;
            chk_q      <= 8'd0;
            reply_b0   <= 8'd0;
            reply_b1   <= 8'd0;
            reply_b2   <= 8'd0;
            reply_idx  <= 2'd0;
            reply_last <= 2'd0;
        end else begin
            cfg_update <= 1'b0;
            gap_q      <= new_tx_data;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (new_rx_data && rx_data == 8'hA5)
                        state <= S_CMD;
                end
                S_CMD, S_DHI, S_DLO, S_CHK: begin
                    // A byte strobe takes priority over timeout expiry.
                    if (new_rx_data) begin
                        to_cnt <= '0;
                        case (state)
                            S_CMD:   cmd_q <= rx_data;
                            S_DHI:   dhi_q <= rx_data;
                            S_DLO:   dlo_q <= rx_data;
                            default: chk_q <= rx_data;
                        endcase
                        state <= state + 3'd1;
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        to_cnt <= '0;
                        state  <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (wr_step) step      <= {dhi_q, dlo_q};
                    if (wr_wave) wave_sel  <= dlo_q[1:0];
                    if (wr_amp)  amplitude <= dlo_q;
                    cfg_update <= changed;
                    reply_b0   <= accept ? 8'h06 : 8'h15;
                    reply_b1   <= step[15:8];
                    reply_b2   <= step[7:0];
                    reply_last <= readback ? 2'd2 : 2'd0;
                    reply_idx  <= 2'd0;
                    state      <= S_REPLY;
                end
                S_REPLY: begin
                    if (new_tx_data) begin
                        tx_hold <= reply_byte;
                        if (reply_idx == reply_last)
                            state <= S_IDLE;
                        else
                            reply_idx <= reply_idx + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_cmd_parser.sv
module tb_wave_cmd_parser;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic [15:0] step;
    logic [1:0]  wave_sel;
    logic [7:0]  amplitude;
    logic        cfg_update;

    wave_cmd_parser #(.TIMEOUT_CYCLES(T), .STEP_RESET(16'd1), .AMP_RESET(8'd255)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .step(step), .wave_sel(wave_sel), .amplitude(amplitude), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: phase 0 hunting sync, 1 collecting 4 bytes,
    // 2 frame complete (evaluated next edge), 3 draining reply queue.
    int          m_phase = 0;
    logic [7:0]  m_buf [4];
    int          m_n, m_idle;
    logic [15:0] m_step;
    logic [1:0]  m_wave;
    logic [7:0]  m_amp;
    logic        m_cfg;
    logic [7:0]  m_reply [$];
    logic [7:0]  m_tx_hold;
    logic        m_last_pulse;
    bit          started = 0;

    function automatic logic m_pulse();
        return !rst && (m_phase == 3) && !tx_busy && !m_last_pulse;
    endfunction

    logic [7:0] fc, fh, fl, fk;
    logic       facc, fp;

    always @(posedge clk) begin
        fp = m_pulse();
        started = 1;
        if (rst) begin
            m_phase = 0; m_step = 16'd1; m_wave = 2'd0; m_amp = 8'hFF;
            m_cfg = 0; m_tx_hold = 8'h00; m_last_pulse = 0; m_reply.delete();
        end else begin
            m_cfg = 0;
            case (m_phase)
                0: if (new_rx_data && rx_data == 8'hA5) begin m_phase = 1; m_n = 0; m_idle = 0; end
                1: if (new_rx_data) begin
                       m_buf[m_n] = rx_data; m_n++; m_idle = 0;
                       if (m_n == 4) m_phase = 2;
                   end else begin
                       m_idle++;
                       if (m_idle == T) m_phase = 0;
                   end
                2: begin
                       fc = m_buf[0]; fh = m_buf[1]; fl = m_buf[2]; fk = m_buf[3];
                       facc = 0;
                       if ((fc ^ fh ^ fl) == fk) begin
                           if (fc == 8'h01 && {fh, fl} != 16'd0) begin
                               facc = 1; m_cfg = (m_step != {fh, fl}); m_step = {fh, fl};
                           end else if (fc == 8'h02 && fl < 8'd4) begin
                               facc = 1; m_cfg = (m_wave != fl[1:0]); m_wave = fl[1:0];
                           end else if (fc == 8'h03) begin
                               facc = 1; m_cfg = (m_amp != fl); m_amp = fl;
                           end
`ifdef WAVE_CMD_READBACK_EN
                           else if (fc == 8'h04) begin
                               m_reply.push_back(8'h06);
                               m_reply.push_back(m_step[15:8]);
                               m_reply.push_back(m_step[7:0]);
                           end
`endif
                       end
                       if (m_reply.size() == 0) m_reply.push_back(facc ? 8'h06 : 8'h15);
                       m_phase = 3;
                   end
                default: if (fp) begin
                       m_tx_hold = m_reply.pop_front();
                       if (m_reply.size() == 0) m_phase = 0;
                   end
            endcase
            m_last_pulse = fp;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] sent [$];
    int         sent_cyc [$];
    int         cfg_cnt = 0;
    int         cyc = 0;
    logic       ep;

    always @(negedge clk) begin
        cyc++;
        if (started) begin
            ep = m_pulse();
            check("step", step, m_step);
            check("wave_sel", wave_sel, m_wave);
            check("amplitude", amplitude, m_amp);
            check("cfg_update", cfg_update, m_cfg);
            check("new_tx_data", new_tx_data, ep);
            check("tx_data", tx_data, ep ? m_reply[0] : m_tx_hold);
            if (new_tx_data === 1'b1) begin sent.push_back(tx_data); sent_cyc.push_back(cyc); end
            if (cfg_update === 1'b1) cfg_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
    endtask

    task automatic clear_log();
        sent.delete(); sent_cyc.delete(); cfg_cnt = 0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
        send_byte(8'hA5); send_byte(c); send_byte(h); send_byte(l); send_byte(k);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
        clear_log();
        send_frame(c, h, l, k);
        repeat (10) tick();
    endtask

    task automatic check_one_reply(input string name, input logic [7:0] exp);
        check({name, "_count"}, sent.size(), 1);
        if (sent.size() > 0) check({name, "_byte"}, sent[0], exp);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0; tx_busy = 1'b0;
        repeat (3) tick();
        check("rst_step", step, 16'h0001);
        check("rst_amp", amplitude, 8'hFF);
        check("rst_wave", wave_sel, 2'd0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_new_tx", new_tx_data, 1'b0);
        rst = 1'b0;
        tick();

        // Basic step write with exact timing.
        clear_log();
        send_frame(8'h01, 8'h00, 8'h10, 8'h11);   // now at N+1
        check("n1_cfg", cfg_update, 1'b0);
        tick();                                     // N+2
        check("n2_step", step, 16'h0010);
        check("n2_cfg", cfg_update, 1'b1);
        tick();
        check("n3_cfg", cfg_update, 1'b0);
        repeat (8) tick();
        check_one_reply("step_ack", 8'h06);
        check("step_cfg_pulses", cfg_cnt, 1);

        frame(8'h03, 8'h00, 8'h80, 8'h83);
        check("amp80", amplitude, 8'h80);
        check_one_reply("amp_ack", 8'h06);
        frame(8'h02, 8'h00, 8'h05, 8'h07);
        check("wave_bad", wave_sel, 2'd0);
        check_one_reply("wave_nak", 8'h15);
        check("wave_bad_cfg", cfg_cnt, 0);
        frame(8'h02, 8'h00, 8'h03, 8'h01);
        check("wave3", wave_sel, 2'd3);
        check_one_reply("wave3_ack", 8'h06);
        frame(8'h01, 8'h00, 8'h00, 8'h01);
        check_one_reply("step0_nak", 8'h15);
        frame(8'h01, 8'h00, 8'h10, 8'h12);
        check_one_reply("badchk_nak", 8'h15);
        check("badchk_cfg", cfg_cnt, 0);
        frame(8'h05, 8'h00, 8'h00, 8'h05);
        check_one_reply("unknown_nak", 8'h15);

        frame(8'h04, 8'h00, 8'h00, 8'h04);
`ifdef WAVE_CMD_READBACK_EN
        check("rb_count", sent.size(), 3);
        if (sent.size() == 3) begin
            check("rb_b0", sent[0], 8'h06);
            check("rb_b1", sent[1], 8'h00);
            check("rb_b2", sent[2], 8'h10);
            check("rb_gap1", (sent_cyc[1] - sent_cyc[0]) >= 2, 1);
            check("rb_gap2", (sent_cyc[2] - sent_cyc[1]) >= 2, 1);
        end
        check("rb_cfg", cfg_cnt, 0);
`else
        check_one_reply("cmd04_nak", 8'h15);
`endif

        // Junk before sync is discarded; 0xA5 inside a frame is data.
        clear_log();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h01);
        frame(8'h03, 8'h00, 8'h40, 8'h43);
        check("junk_amp", amplitude, 8'h40);
        check_one_reply("junk_ack", 8'h06);
        frame(8'h03, 8'hA5, 8'h10, 8'hB6);
        check("a5data_amp", amplitude, 8'h10);
        check_one_reply("a5data_ack", 8'h06);

        // Timeout abandons the frame silently.
        clear_log();
        send_byte(8'hA5); send_byte(8'h01);
        repeat (T + 5) tick();
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h21);
        repeat (10) tick();
        check("to_reply_count", sent.size(), 0);
        check("to_step", step, 16'h0010);
        frame(8'h01, 8'h00, 8'h20, 8'h21);
        check("to_after_step", step, 16'h0020);
        check_one_reply("to_after_ack", 8'h06);

        // Byte arriving in the expiry cycle wins.
        clear_log();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        repeat (T - 1) tick();
        send_byte(8'h30); send_byte(8'h31);
        repeat (10) tick();
        check("edge_step", step, 16'h0030);
        check_one_reply("edge_ack", 8'h06);

        // Transmitter busy: reply held; bytes during reply dropped.
        clear_log();
        tx_busy = 1'b1;
        send_frame(8'h03, 8'h00, 8'h55, 8'h56);
        send_frame(8'h01, 8'h00, 8'h10, 8'h11);
        repeat (90) tick();
        check("busy_none", sent.size(), 0);
        check("busy_amp", amplitude, 8'h55);
        tx_busy = 1'b0;
        repeat (6) tick();
        check_one_reply("busy_ack", 8'h06);
        check("busy_drop_step", step, 16'h0030);

        // Reset mid-frame.
        clear_log();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mf_step", step, 16'h0001);
        check("mf_amp", amplitude, 8'hFF);
        check("mf_wave", wave_sel, 2'd0);
        check("mf_tx_data", tx_data, 8'h00);
        send_byte(8'h10); send_byte(8'h11);
        repeat (10) tick();
        check("mf_none", sent.size(), 0);
        frame(8'h01, 8'h00, 8'h10, 8'h11);
        check("mf_next_step", step, 16'h0010);
        check_one_reply("mf_next_ack", 8'h06);

        // Reset mid-reply.
        clear_log();
        tx_busy = 1'b1;
        send_frame(8'h03, 8'h00, 8'h22, 8'h21);
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tx_busy = 1'b0;
        repeat (10) tick();
        check("mr_none", sent.size(), 0);
        check("mr_amp", amplitude, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
